// File: rtl/aes_pkg.sv
// Shared AES loader definitions: FSM state type and default word/block widths.
package aes_pkg;

    localparam int AES_WORD_W  = 32;
    localparam int AES_BLOCK_W = 128;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } loader_state_t;

endpackage

// File: rtl/d_ff.sv
// Generic register with asynchronous active-low clear.
module d_ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/aes_block_loader.sv
// Packs a stream of WORD_W words into BLOCK_W blocks (word 0 in the MSBs).
// Optional AES_LOADER_BSWAP_EN byte-reverses each word before it is stored.
module aes_block_loader
    import aes_pkg::*;
#(
    parameter  int WORD_W  = AES_WORD_W,
    parameter  int BLOCK_W = AES_BLOCK_W,
    localparam int NWORDS  = BLOCK_W / WORD_W,
    localparam int CNT_W   = $clog2(NWORDS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORD_W-1:0]  in_word,
    input  logic               in_first,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_block,
    output logic [CNT_W-1:0]   word_cnt
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    loader_state_t      state_reg;
    loader_state_t      state_next;
    logic [CNT_W-1:0]   cnt_next;
    logic [CNT_W-1:0]   slot_sel;
    logic               slot_we;
    logic [WORD_W-1:0]  word_store;

`ifdef AES_LOADER_BSWAP_EN
    // Byte 0 (LSB byte) of the incoming word lands in the MSB byte.
    for (genvar gi = 0; gi < WORD_W / 8; gi++) begin : g_bswap
        assign word_store[gi*8 +: 8] = in_word[WORD_W-8-gi*8 +: 8];
    end
`else
    assign word_store = in_word;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= FILL;
        end else begin
            state_reg <= state_next;
        end
    end

    d_ff #(
        .WIDTH (CNT_W)
    ) u_word_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (cnt_next),
        .q     (word_cnt)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = word_cnt;
        slot_sel   = word_cnt;
        slot_we    = 1'b0;
        in_ready   = 1'b1;
        out_valid  = 1'b0;
        case (state_reg)
            FILL: begin
                if (in_valid) begin
                    slot_we = 1'b1;
                    if (in_first) begin
                        // Resync: whatever partial block exists is abandoned.
                        slot_sel = '0;
                        cnt_next = ONE_CNT;
                    end else if (word_cnt == LAST_IDX) begin
                        cnt_next   = '0;
                        state_next = FULL;
                    end else begin
                        cnt_next = word_cnt + ONE_CNT;
                    end
                end
            end
            FULL: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    // Draining and accepting word 0 of the next block in the same cycle.
                    state_next = FILL;
                    slot_sel   = '0;
                    if (in_valid) begin
                        slot_we  = 1'b1;
                        cnt_next = ONE_CNT;
                    end else begin
                        cnt_next = '0;
                    end
                end
            end
            default: begin
                state_next = FILL;
            end
        endcase
    end

    for (genvar gi = 0; gi < NWORDS; gi++) begin : g_slot
        logic [WORD_W-1:0] slot_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                slot_reg <= '0;
            end else if (slot_we && (slot_sel == CNT_W'(gi))) begin
                slot_reg <= word_store;
            end
        end

        assign out_block[BLOCK_W-1-gi*WORD_W -: WORD_W] = slot_reg;
    end

endmodule

// File: tb/tb_aes_block_loader.sv
// Self-checking bench for aes_block_loader: vector table, corner sequences, random vs. model.
module tb_aes_block_loader;

    localparam int WW = 32;
    localparam int BW = 128;
    localparam int NW = BW / WW;
    localparam int CW = $clog2(NW);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [WW-1:0] in_word = '0;
    logic          in_first = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [BW-1:0] out_block;
    logic [CW-1:0] word_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    aes_block_loader #(
        .WORD_W  (WW),
        .BLOCK_W (BW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .in_first  (in_first),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          vin;
        logic          first;
        logic          ordy;
        logic [WW-1:0] word;
        logic          exp_rdy;
        logic          exp_ov;
        logic [CW-1:0] exp_cnt;
        logic [BW-1:0] exp_blk;
    } vec_t;

    vec_t vecs[$];

    // Storage form of a word as seen in out_block.
    function automatic logic [WW-1:0] sw(input logic [WW-1:0] w);
`ifdef AES_LOADER_BSWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic add_vec(input logic vin, input logic first, input logic ordy, input logic [WW-1:0] w,
                           input logic erdy, input logic eov, input int ecnt, input logic [BW-1:0] eblk);
        vec_t v;
        v.vin = vin; v.first = first; v.ordy = ordy; v.word = w;
        v.exp_rdy = erdy; v.exp_ov = eov; v.exp_cnt = CW'(ecnt); v.exp_blk = eblk;
        vecs.push_back(v);
    endtask

    // Called at posedge+1: applies inputs, samples in_ready, advances one edge to posedge+1.
    task automatic drive_cycle(input logic vin, input logic first, input logic ordy,
                               input logic [WW-1:0] w, output logic rdy_seen);
        in_valid  = vin;
        in_first  = first;
        out_ready = ordy;
        in_word   = w;
        #1;
        rdy_seen = in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_first = 1'b0; out_ready = 1'b0;
        #1;
        check("reset_in_ready", BW'(in_ready), BW'(1));
        check("reset_out_valid", BW'(out_valid), BW'(0));
        check("reset_word_cnt", BW'(word_cnt), BW'(0));
        check("reset_out_block", out_block, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("post_reset_in_ready", BW'(in_ready), BW'(1));
        @(posedge clk);
        #1;
    endtask

    // Block-level reference: a block image, a fill count and a "presented" flag.
    logic [BW-1:0] m_blk;
    int            m_cnt;
    bit            m_full;

    task automatic model_put(input int k, input logic [WW-1:0] w);
        m_blk[BW-1-k*WW -: WW] = sw(w);
    endtask

    task automatic model_step(input logic vin, input logic first, input logic ordy, input logic [WW-1:0] w,
                              output logic exp_rdy);
        logic acc;
        exp_rdy = !m_full || ordy;
        acc     = vin && exp_rdy;
        if (m_full) begin
            if (ordy) begin
                m_full = 1'b0;
                m_cnt  = 0;
                if (acc) begin
                    model_put(0, w);
                    m_cnt = 1;
                end
            end
        end else if (acc) begin
            if (first) begin
                model_put(0, w);
                m_cnt = 1;
            end else begin
                model_put(m_cnt, w);
                m_cnt = m_cnt + 1;
                if (m_cnt == NW) begin
                    m_full = 1'b1;
                    m_cnt  = 0;
                end
            end
        end
    endtask

    localparam logic [WW-1:0] W0 = 32'h00112233, W1 = 32'h44556677, W2 = 32'h8899AABB, W3 = 32'hCCDDEEFF;
    localparam logic [WW-1:0] WA = 32'h11111111, WB = 32'h22222222, WD = 32'hDEADBEEF;
    localparam logic [WW-1:0] WC = 32'h33333333, WE = 32'h55555555, WF = 32'h66666666, WG = 32'h77777777;

    initial begin
        logic rdy;
        logic exp_rdy;
        logic [BW-1:0] blk_a;
        logic [BW-1:0] blk_b;

        // Scenario 1: straight fill, then drain with nothing pending.
        add_vec(1, 0, 1, W0, 1, 0, 1, {sw(W0), 96'h0});
        add_vec(1, 0, 1, W1, 1, 0, 2, {sw(W0), sw(W1), 64'h0});
        add_vec(1, 0, 1, W2, 1, 0, 3, {sw(W0), sw(W1), sw(W2), 32'h0});
        add_vec(1, 0, 1, W3, 1, 1, 0, {sw(W0), sw(W1), sw(W2), sw(W3)});
        add_vec(0, 0, 1, WF, 1, 0, 0, {sw(W0), sw(W1), sw(W2), sw(W3)});
        // Scenario 4: two stale words, then a resync on 0xDEADBEEF.
        add_vec(1, 0, 1, WA, 1, 0, 1, {sw(WA), sw(W1), sw(W2), sw(W3)});
        add_vec(1, 0, 1, WB, 1, 0, 2, {sw(WA), sw(WB), sw(W2), sw(W3)});
        add_vec(1, 1, 1, WD, 1, 0, 1, {sw(WD), sw(WB), sw(W2), sw(W3)});
        add_vec(1, 0, 1, WC, 1, 0, 2, {sw(WD), sw(WC), sw(W2), sw(W3)});
        add_vec(1, 0, 1, WA, 1, 0, 3, {sw(WD), sw(WC), sw(WA), sw(W3)});
        add_vec(1, 0, 0, WE, 1, 1, 0, {sw(WD), sw(WC), sw(WA), sw(WE)});
        // Scenario 2: five cycles of backpressure while FULL, upstream keeps offering.
        for (int i = 0; i < 5; i++) begin
            add_vec(1, 0, 0, WF, 0, 1, 0, {sw(WD), sw(WC), sw(WA), sw(WE)});
        end
        // Release: drain and take word 0 of the next block in the same cycle.
        add_vec(1, 0, 1, WG, 1, 0, 1, {sw(WG), sw(WC), sw(WA), sw(WE)});

        do_reset();
        foreach (vecs[i]) begin
            drive_cycle(vecs[i].vin, vecs[i].first, vecs[i].ordy, vecs[i].word, rdy);
            $display("vec %0d: in_ready=%0d out_valid=%0d word_cnt=%0d out_block=%h",
                     i, rdy, out_valid, word_cnt, out_block);
            check($sformatf("vec%0d_in_ready", i), BW'(rdy), BW'(vecs[i].exp_rdy));
            check($sformatf("vec%0d_out_valid", i), BW'(out_valid), BW'(vecs[i].exp_ov));
            check($sformatf("vec%0d_word_cnt", i), BW'(word_cnt), BW'(vecs[i].exp_cnt));
            check($sformatf("vec%0d_out_block", i), out_block, vecs[i].exp_blk);
            if (i == 3) begin
`ifdef AES_LOADER_BSWAP_EN
                check("bswap_word0", BW'(out_block[BW-1 -: WW]), BW'(32'h33221100));
`else
                check("scn1_block", out_block, 128'h00112233_44556677_8899AABB_CCDDEEFF);
`endif
            end
        end

        // Scenario 3: eight words back-to-back, two blocks, no bubble.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b1, 1'b0, 1'b1, WW'(32'hA0000000 + i), rdy);
            check($sformatf("stream%0d_in_ready", i), BW'(rdy), BW'(1));
            if (i == 3 || i == 7) begin
                blk_a = {sw(WW'(32'hA0000000 + i - 3)), sw(WW'(32'hA0000000 + i - 2)),
                         sw(WW'(32'hA0000000 + i - 1)), sw(WW'(32'hA0000000 + i))};
                $display("stream block delivered: %h", out_block);
                check($sformatf("stream%0d_out_valid", i), BW'(out_valid), BW'(1));
                check($sformatf("stream%0d_out_block", i), out_block, blk_a);
            end else begin
                check($sformatf("stream%0d_out_valid", i), BW'(out_valid), BW'(0));
            end
        end
        drive_cycle(1'b0, 1'b0, 1'b1, '0, rdy);
        check("stream_drained", BW'(out_valid), BW'(0));

        // Scenario 5a: async reset after three words.
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, 1'b1, WW'(32'hB0000000 + i), rdy);
        check("mid_cnt_before_reset", BW'(word_cnt), BW'(3));
        rst_n = 1'b0;
        #1;
        check("async_mid_out_valid", BW'(out_valid), BW'(0));
        check("async_mid_word_cnt", BW'(word_cnt), BW'(0));
        check("async_mid_out_block", out_block, '0);
        check("async_mid_in_ready", BW'(in_ready), BW'(1));
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("mid_release_in_ready", BW'(in_ready), BW'(1));
        @(posedge clk); #1;

        // Scenario 5b: async reset while a block is held.
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, 1'b0, 1'b0, WW'(32'hC0000000 + i), rdy);
        check("held_out_valid", BW'(out_valid), BW'(1));
        rst_n = 1'b0;
        #1;
        check("async_full_out_valid", BW'(out_valid), BW'(0));
        check("async_full_word_cnt", BW'(word_cnt), BW'(0));
        check("async_full_out_block", out_block, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Randomized traffic against the reference model.
        do_reset();
        m_blk = '0; m_cnt = 0; m_full = 1'b0;
        for (int i = 0; i < 800; i++) begin
            logic vin, first, ordy;
            logic [WW-1:0] w;
            vin   = ($urandom_range(0, 3) != 0);
            first = ($urandom_range(0, 11) == 0);
            ordy  = ($urandom_range(0, 2) != 0);
            w     = $urandom;
            model_step(vin, first, ordy, w, exp_rdy);
            drive_cycle(vin, first, ordy, w, rdy);
            check($sformatf("rnd%0d_in_ready", i), BW'(rdy), BW'(exp_rdy));
            check($sformatf("rnd%0d_out_valid", i), BW'(out_valid), BW'(m_full));
            check($sformatf("rnd%0d_word_cnt", i), BW'(word_cnt), BW'(m_cnt));
            check($sformatf("rnd%0d_out_block", i), out_block, m_blk);
            if (m_full && ordy) begin
                blk_b = out_block;
                $display("rnd %0d: block presented %h", i, blk_b);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/aes_block_loader.md
AES_BLOCK_LOADER -- requirements
Module: aes_block_loader

Interface
REQ-001 The block SHALL have parameter WORD_W, default 32, meaning input word width in bits.
REQ-002 The block SHALL have parameter BLOCK_W, default 128, meaning output block width in bits; BLOCK_W SHALL be an integer multiple (at least 2) of WORD_W, with NWORDS = BLOCK_W/WORD_W.
REQ-003 The block SHALL have port clk  input  1  the single clock; all flops are rising-edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port in_valid  input  1  upstream word valid.
REQ-006 The block SHALL have port in_ready  output  1  loader can accept a word.
REQ-007 The block SHALL have port in_word  input  WORD_W  data word.
REQ-008 The block SHALL have port in_first  input  1  qualifies in_word as word 0 of a new block (resync).
REQ-009 The block SHALL have port out_valid  output  1  assembled block valid to the downstream state register.
REQ-010 The block SHALL have port out_ready  input  1  downstream accepts the block.
REQ-011 The block SHALL have port out_block  output  BLOCK_W  assembled block.
REQ-012 The block SHALL have port word_cnt  output  $clog2(NWORDS)  number of words currently held in a partial block.

Function
REQ-013 A word SHALL be accepted when in_valid and in_ready are both high on a rising clk edge.
REQ-014 The block SHALL implement two states: FILL (collecting words) and FULL (block presented).
REQ-015 In FILL, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-016 Word k of a block (k = 0..NWORDS-1) SHALL be written to out_block[BLOCK_W-1-k*WORD_W -: WORD_W]; word 0 occupies the MSBs (AES column 0).
REQ-017 On accepting word NWORDS-1 in FILL, the block SHALL enter FULL with out_valid=1 on the next cycle; latency is one cycle from the last word to out_valid.
REQ-018 In FULL, out_block and out_valid SHALL hold stable until out_valid and out_ready are both high.
REQ-019 In FULL, in_ready SHALL equal out_ready.
REQ-020 In FULL, with out_ready=1 and no word accepted, the block SHALL return to FILL with word_cnt=0.
REQ-021 In FULL, with out_ready=1 and a word accepted, the block SHALL drain the current block, write the new word to slot 0, and go to FILL with word_cnt=1 (zero-bubble streaming).
REQ-022 A word accepted with in_first=1 in FILL SHALL discard any partial block, be written to slot 0, and set word_cnt=1; when NWORDS words are streamed, in_first on word 0 SHALL have no other effect.
REQ-023 Unwritten slots of a partial block SHALL retain their previous contents; no zero-fill is required.
REQ-024 word_cnt SHALL wrap to 0 when the block enters FULL.

Reset
REQ-025 Asserting rst_n low SHALL immediately force state=FILL, word_cnt=0, out_valid=0, and out_block=0, including mid-block or while in FULL; a held block SHALL be lost.
REQ-026 in_ready SHALL be 1 while in reset and in the first cycle after reset release.

Configuration
REQ-027 With macro AES_LOADER_BSWAP_EN defined, each accepted word SHALL be byte-reversed before it is stored (byte 0 to MSB byte); without the macro, words SHALL be stored unmodified.
REQ-028 With AES_LOADER_BSWAP_EN defined, WORD_W SHALL be a multiple of 8.

Structure
REQ-029 The state enum (FILL, FULL) and the default WORD_W/BLOCK_W constants SHALL reside in the shared package aes_pkg.
REQ-030 The word counter register SHALL be an instance of the existing d_ff sub-module (WIDTH=$clog2(NWORDS)); the data slots and the FSM SHALL be local.

Verification
REQ-031 Scenario 1: after reset, send words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF with out_ready=1 -> out_valid high one cycle after the 4th word with out_block=0x00112233_44556677_8899AABB_CCDDEEFF.
REQ-032 Scenario 2: hold out_ready=0 for 5 cycles in FULL -> out_block stable, in_ready=0, and no further words accepted.
REQ-033 Scenario 3: stream 8 words back-to-back with out_ready=1 -> two blocks delivered, in_ready never low, and no bubble.
REQ-034 Scenario 4: send 2 words, then 0xDEADBEEF with in_first=1 plus 3 more words -> the block's MSB word is 0xDEADBEEF and the partial words are discarded.
REQ-035 Scenario 5: assert rst_n low after 3 words, or in FULL -> out_valid=0, word_cnt=0, and out_block=0 asynchronously, before the next clk edge.
REQ-036 Scenario 6: with AES_LOADER_BSWAP_EN defined, send word 0x00112233 -> it is stored as 0x33221100.
